multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates occur on the rising edge.
REQ-002 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: op in 7 (opcode), funct3 in 3, funct7b5 in 1, Zero in 1 (ALU zero flag), MemReady in 1 (memory access complete this cycle).
REQ-004 SHALL have outputs: PCWrite 1, AdrSrc 1 (0 = PC, 1 = Result), MemWrite 1, IRWrite 1, RegWrite 1, Illegal 1.
REQ-005 SHALL have outputs: ResultSrc 2 (00 = ALUOut, 01 = Data, 10 = ALUResult), ImmSrc 2 (00 = I, 01 = S, 10 = B, 11 = J).
REQ-006 SHALL have outputs: ALUSrcA 2 (00 = PC, 01 = OldPC, 10 = A), ALUSrcB 2 (00 = WriteData, 01 = ImmExt, 10 = constant 4), ALUControl 4.

Function
REQ-007 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, JALR and ILLEGAL, encoded in 4 bits.
REQ-008 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10; IRWrite=PCUpdate=MemReady; go to DECODE when MemReady=1, otherwise hold.
REQ-009 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add; the next state is selected by op.
REQ-010 DECODE op map: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; 1100111 -> JALR; any other op -> ILLEGAL.
REQ-011 MEMADR: ALUSrcA=10, ALUSrcB=01, add; go to MEMREAD if op=0000011, otherwise MEMWRITE.
REQ-012 MEMREAD: ResultSrc=00, AdrSrc=1; go to MEMWB when MemReady=1, otherwise hold.
REQ-013 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 for every cycle in the state; go to FETCH when MemReady=1.
REQ-014 MEMWB: ResultSrc=01, RegWrite=1; go to FETCH.
REQ-015 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=funct; go to ALUWB.
REQ-016 EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct; go to ALUWB.
REQ-017 ALUWB: ResultSrc=00, RegWrite=1; go to FETCH.
REQ-018 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, Branch=1; go to FETCH.
REQ-019 JALR: ALUSrcA=10, ALUSrcB=01, add (rs1+imm into ALUOut); go to JAL.
REQ-020 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCUpdate=1; go to ALUWB.
REQ-021 PCWrite SHALL equal (Branch & Zero) | PCUpdate, evaluated combinationally in the same cycle.
REQ-022 ImmSrc SHALL be decoded combinationally from op: lw/I-ALU/jalr -> 00, sw -> 01, beq -> 10, jal -> 11, any other op -> 00.
REQ-023 ALUOp (add = 00, sub = 01, funct = 10) SHALL drive the existing aludec together with op[5], funct3 and funct7b5 to produce ALUControl.
REQ-024 ILLEGAL SHALL be sticky until reset: Illegal=1, and every write enable (PCWrite, IRWrite, MemWrite, RegWrite) SHALL be 0.
REQ-025 Any select not listed for a state SHALL be driven to 00/0, and every write enable SHALL be 0 outside the states named above.
REQ-026 Latency in cycles, counted from FETCH entry with MemReady held at 1: lw 5; sw, R-type, I-ALU and jal 4; beq 3; jalr 5.
REQ-027 MemReady=0 SHALL add one wait cycle per cycle low in FETCH, MEMREAD and MEMWRITE, with no IRWrite or PCWrite during the wait; MemReady is ignored in all other states.

Reset
REQ-028 reset_n=0 SHALL asynchronously force the state to FETCH, including mid-instruction and from ILLEGAL.
REQ-029 While reset_n=0, the outputs SHALL be: MemWrite=RegWrite=IRWrite=PCWrite=Illegal=0.

Structure
REQ-030 State enum, opcode constants, and the ALUOp, ALUSrcA, ALUSrcB, ResultSrc and ImmSrc encodings SHALL live in the shared package riscv_pkg.
REQ-031 SHALL instantiate exactly one sub-module, aludec; the FSM and the ImmSrc decode SHALL be inline.

Verification
REQ-032 lw, MemReady=1: state trace FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 with ResultSrc=01 in cycle 5 only.
REQ-033 beq: Zero=1 -> PCWrite=1 in BEQ; Zero=0 -> PCWrite=0; ALUControl selects subtract in both cases.
REQ-034 sw with MemReady low 3 cycles in MEMWRITE: MemWrite=1 for 4 cycles, then FETCH.
REQ-035 jalr: JALR,JAL,ALUWB; PCWrite=1 only in JAL; ImmSrc=00 throughout.
REQ-036 op=1111111 -> ILLEGAL, Illegal=1 for 10 cycles, no write enables; then pulse reset_n low mid-cycle -> immediate FETCH, Illegal=0.
REQ-037 reset_n asserted in MEMWRITE with MemWrite=1: MemWrite drops without a clock edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states,
// opcodes, datapath mux selects and ALU control codes.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_A     = 2'b10
  } srca_e;

  typedef enum logic [1:0] {
    SRCB_WDATA = 2'b00,
    SRCB_IMM   = 2'b01,
    SRCB_FOUR  = 2'b10
  } srcb_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_e;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  function automatic imm_e imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: turns the FSM's coarse ALU operation plus instruction
// function fields into a concrete ALU control code.
module aludec
  import riscv_pkg::*;
(
  input  logic       opb5_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  aluop_e     alu_op_i,
  output logic [3:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // funct7b5 only means subtract for register-register ops
          3'b000:  alu_control_o = (opb5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control_o = ALU_SLL;
          3'b010:  alu_control_o = ALU_SLT;
          3'b011:  alu_control_o = ALU_SLTU;
          3'b100:  alu_control_o = ALU_XOR;
          3'b101:  alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control_o = ALU_OR;
          default: alu_control_o = ALU_AND;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch, decode,
// memory, execute and writeback, with inline ImmSrc decode.
//
// state      | meaning
// FETCH      | read instruction, PC+4; waits on MemReady
// DECODE     | PC+imm speculatively into ALUOut, dispatch on op
// MEMADR     | rs1+imm address for load/store
// MEMREAD    | load data read; waits on MemReady
// MEMWB      | load data to register file
// MEMWRITE   | store; waits on MemReady
// EXECUTER   | register-register ALU op
// EXECUTEI   | register-immediate ALU op
// ALUWB      | ALUOut to register file
// BEQ        | compare, branch to PC+imm on Zero
// JALR       | rs1+imm into ALUOut
// JAL        | PC <- ALUOut, OldPC+4 into ALUOut
// ILLEGAL    | unsupported opcode, sticky until reset
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       Illegal,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl
);

  state_e  state_q, state_d;
  logic    adr_src, ir_write, pc_update, branch, mem_write, reg_write, illegal;
  result_e result_src;
  srca_e   srca;
  srcb_e   srcb;
  aluop_e  alu_op;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = MemReady ? S_FETCH : S_MEMWRITE;
      S_MEMWB:    state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    result_src = RES_ALUOUT;
    srca       = SRCA_PC;
    srcb       = SRCB_WDATA;
    alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        srcb       = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = MemReady;
        pc_update  = MemReady;
      end
      S_DECODE:   begin srca = SRCA_OLDPC; srcb = SRCB_IMM; end
      S_MEMADR:   begin srca = SRCA_A;     srcb = SRCB_IMM; end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWRITE: begin adr_src = 1'b1; mem_write = 1'b1; end
      S_MEMWB:    begin result_src = RES_DATA; reg_write = 1'b1; end
      S_EXECUTER: begin srca = SRCA_A; alu_op = ALUOP_FUNCT; end
      S_EXECUTEI: begin srca = SRCA_A; srcb = SRCB_IMM; alu_op = ALUOP_FUNCT; end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ:      begin srca = SRCA_A; alu_op = ALUOP_SUB; branch = 1'b1; end
      S_JALR:     begin srca = SRCA_A; srcb = SRCB_IMM; end
      S_JAL:      begin srca = SRCA_OLDPC; srcb = SRCB_FOUR; pc_update = 1'b1; end
      S_ILLEGAL:  illegal = 1'b1;
      default:    ;
    endcase
  end

  // Enables are gated by reset_n so they drop without waiting for a clock
  assign PCWrite    = reset_n & ((branch & Zero) | pc_update);
  assign IRWrite    = reset_n & ir_write;
  assign MemWrite   = reset_n & mem_write;
  assign RegWrite   = reset_n & reg_write;
  assign Illegal    = reset_n & illegal;
  assign AdrSrc     = adr_src;
  assign ResultSrc  = result_src;
  assign ALUSrcA    = srca;
  assign ALUSrcB    = srcb;
  assign ImmSrc     = imm_src_of(op);

  aludec u_aludec (
    .opb5_i        (op[5]),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .alu_op_i      (alu_op),
    .alu_control_o (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed vector table,
// hand-written reset/illegal/wait sequences, and randomized instruction stream.
module tb_multicycle_controller;
  import riscv_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ImmSrc, ALUSrcA, ALUSrcB;
  logic [3:0] ALUControl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .Illegal    (Illegal),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl)
  );

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4, C_JAL = 5, C_JALR = 6;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       zero;
    bit         chk_alu;
    logic [3:0] exp_alu;
    int         exp_lat;
    int         exp_pcw;
    int         exp_rw;
    logic [1:0] exp_imm;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] cls_op(input int cls);
    case (cls)
      C_LW:    return 7'b0000011;
      C_SW:    return 7'b0100011;
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_BEQ:   return 7'b1100011;
      C_JAL:   return 7'b1101111;
      default: return 7'b1100111;
    endcase
  endfunction

  function automatic logic [1:0] model_imm(input int cls);
    case (cls)
      C_SW:    return 2'b01;
      C_BEQ:   return 2'b10;
      C_JAL:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Operation named by the RISC-V function fields
  function automatic logic [3:0] model_alu(input bit is_r, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (is_r && f7) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return f7 ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic int base_lat(input int cls);
    case (cls)
      C_LW, C_JALR: return 5;
      C_BEQ:        return 3;
      default:      return 4;
    endcase
  endfunction

  task automatic do_reset();
    reset_n  = 1'b0;
    MemReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Called at posedge+1 with the DUT expected in FETCH; returns at posedge+1
  task automatic check_fetch(input string name);
    MemReady = 1'b1;
    #1;
    chk(name, 32'({IRWrite, PCWrite, Illegal}), 32'(3'b110));
    MemReady = 1'b0;
    @(posedge clk); #1;
  endtask

  // One instruction with wf fetch wait cycles and wm memory wait cycles,
  // checked cycle by cycle against the expected timeline.
  task automatic run_instr(input int cls, input logic [2:0] f3, input logic f7,
                           input logic zero, input int wf, input int wm_in);
    int  total, m0, wm;
    bit  mem, wreg, e_ir, e_pcw, e_rw, e_mw, e_adr;
    mem   = (cls == C_LW) || (cls == C_SW);
    wreg  = (cls != C_SW) && (cls != C_BEQ);
    wm    = mem ? wm_in : 0;
    total = base_lat(cls) + wf + wm;
    m0    = wf + 3;
    op = cls_op(cls); funct3 = f3; funct7b5 = f7;
    for (int c = 0; c < total; c++) begin
      if (c <= wf)                             MemReady = (c == wf);
      else if (mem && c >= m0 && c <= m0 + wm) MemReady = (c == m0 + wm);
      else                                     MemReady = 1'($urandom_range(0, 1));
      Zero = (cls == C_BEQ && c == wf + 2) ? zero : 1'($urandom_range(0, 1));
      #4;
      e_ir  = (c == wf);
      e_pcw = (c == wf) || (cls == C_JAL && c == wf + 2) || (cls == C_JALR && c == wf + 3)
              || (cls == C_BEQ && zero && c == wf + 2);
      e_rw  = wreg && (c == total - 1);
      e_mw  = (cls == C_SW) && c >= m0 && c <= m0 + wm;
      e_adr = mem && c >= m0 && c <= m0 + wm;
      chk("enables", 32'({PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, Illegal}),
          32'({e_pcw, e_ir, e_rw, e_mw, e_adr, 1'b0}));
      chk("immsrc", 32'(ImmSrc), 32'(model_imm(cls)));
      if (c == wf + 2 && (cls == C_R || cls == C_I || cls == C_BEQ))
        chk("alucontrol", 32'(ALUControl),
            32'((cls == C_BEQ) ? ALU_SUB : model_alu(cls == C_R, f3, f7)));
      if (e_rw) chk("resultsrc_wb", 32'(ResultSrc), 32'((cls == C_LW) ? 2'b01 : 2'b00));
      if (c <= wf) chk("fetch_selects", 32'({ALUSrcA, ALUSrcB, ResultSrc}), 32'(6'b00_10_10));
      @(posedge clk); #1;
    end
    MemReady = 1'b0;
  endtask

  // Table executor: measures latency as the distance between IRWrite pulses
  task automatic run_vec(input vec_t v);
    int lat, pcw, rw;
    bit done;
    logic [1:0] imm;
    lat = 0; pcw = 0; rw = 0; done = 1'b0; imm = 2'b00;
    op = v.op; funct3 = v.f3; funct7b5 = v.f7; Zero = v.zero;
    for (int c = 0; c < 12 && !done; c++) begin
      MemReady = 1'b1;
      #4;
      if (c > 0 && IRWrite) begin
        lat = c; done = 1'b1; MemReady = 1'b0;
      end else begin
        pcw += int'(PCWrite);
        rw  += int'(RegWrite);
        if (c == 0) imm = ImmSrc;
        if (c == 2 && v.chk_alu) chk("vec_alu", 32'(ALUControl), 32'(v.exp_alu));
      end
      @(posedge clk); #1;
    end
    chk("vec_latency", 32'(lat), 32'(v.exp_lat));
    chk("vec_pcwrite_count", 32'(pcw), 32'(v.exp_pcw));
    chk("vec_regwrite_count", 32'(rw), 32'(v.exp_rw));
    chk("vec_immsrc", 32'(imm), 32'(v.exp_imm));
    if (!done) do_reset();
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, ALU_ADD, 5, 1, 1, 2'b00};
    vecs[1] = '{7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, ALU_ADD, 4, 1, 0, 2'b01};
    vecs[2] = '{7'b0110011, 3'd0, 1'b0, 1'b0, 1'b1, ALU_ADD, 4, 1, 1, 2'b00};
    vecs[3] = '{7'b0110011, 3'd0, 1'b1, 1'b0, 1'b1, ALU_SUB, 4, 1, 1, 2'b00};
    vecs[4] = '{7'b0010011, 3'd0, 1'b1, 1'b0, 1'b1, ALU_ADD, 4, 1, 1, 2'b00};
    vecs[5] = '{7'b1100011, 3'd0, 1'b0, 1'b1, 1'b1, ALU_SUB, 3, 2, 0, 2'b10};
    vecs[6] = '{7'b1100011, 3'd0, 1'b0, 1'b0, 1'b1, ALU_SUB, 3, 1, 0, 2'b10};
    vecs[7] = '{7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0, ALU_ADD, 4, 2, 1, 2'b11};
    vecs[8] = '{7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, ALU_ADD, 5, 2, 1, 2'b00};

    reset_n = 1'b0; op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
    MemReady = 1'b1;
    #12;
    chk("reset_enables", 32'({PCWrite, IRWrite, RegWrite, MemWrite, Illegal}), 32'(0));
    MemReady = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_fetch("fetch_after_reset");

    foreach (vecs[i]) run_vec(vecs[i]);

    run_instr(C_LW, 3'd2, 1'b0, 1'b0, 0, 0);
    run_instr(C_LW, 3'd2, 1'b0, 1'b0, 2, 2);
    run_instr(C_SW, 3'd2, 1'b0, 1'b0, 0, 3);
    run_instr(C_JALR, 3'd0, 1'b0, 1'b0, 1, 0);
    run_instr(C_BEQ, 3'd0, 1'b0, 1'b1, 0, 0);
    run_instr(C_BEQ, 3'd0, 1'b0, 1'b0, 0, 0);

    // Illegal opcode: sticky, no enables, cleared by a mid-cycle reset pulse
    op = 7'b1111111; MemReady = 1'b1;
    #4; chk("illegal_fetch_ir", 32'(IRWrite), 32'(1));
    @(posedge clk); #1;
    #4; chk("illegal_decode", 32'(Illegal), 32'(0));
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      op = cls_op($urandom_range(0, 6));
      MemReady = 1'($urandom_range(0, 1));
      Zero = 1'($urandom_range(0, 1));
      #4;
      chk("illegal_hold", 32'({Illegal, PCWrite, IRWrite, RegWrite, MemWrite}), 32'(5'b10000));
      @(posedge clk); #1;
    end
    MemReady = 1'b1;
    #2 reset_n = 1'b0;
    #1 chk("illegal_async_reset", 32'({Illegal, PCWrite, IRWrite, RegWrite, MemWrite}), 32'(0));
    #2 reset_n = 1'b1; MemReady = 1'b0;
    @(posedge clk); #1;
    check_fetch("fetch_after_illegal");

    // Reset asserted while a store is waiting in MEMWRITE
    op = cls_op(C_SW); funct3 = 3'd2; MemReady = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    MemReady = 1'b0;
    #4 chk("memwrite_before_reset", 32'(MemWrite), 32'(1));
    #1 reset_n = 1'b0;
    #1 chk("memwrite_async_drop", 32'(MemWrite), 32'(0));
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check_fetch("fetch_after_memwrite_reset");

    for (int n = 0; n < 150; n++) begin
      run_instr($urandom_range(0, 6), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
